interp_loop_ctrl: RTL

Loop sequencer for the interpolation FIR datapath: runs the nested row/tap loops of one filtering job and issues accumulator and coefficient-select controls for each step. It owns the row and tap loop counters internally and presents them as index outputs to the coefficient mux and sample-window mux. It delivers one filtered result per row through a valid/ready handshake. It sits between the top-level job control, which issues START and ABORT, and the MAC datapath plus the downstream sample buffer.

---
 rtl/interp_loop_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/interp_loop_ctrl.sv
// Row/tap loop sequencer for the interpolation FIR MAC datapath.
// Runs one filtering job per START and hands each row result downstream over OUT_VALID/OUT_READY.
module interp_loop_ctrl #(
  parameter int unsigned LUMA_TAPS   = 8,
  parameter int unsigned CHROMA_TAPS = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             CLK,
  input  logic             RST_ASYNC_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             FILTER_SEL,
  input  logic [CNT_W-1:0] NUM_ROWS,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] TAP_IDX,
  output logic [CNT_W-1:0] ROW_IDX,
  output logic             ACC_CLR,
  output logic             ACC_EN,
  output logic             OUT_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StClr  = 3'd1;
  localparam logic [2:0] StMac  = 3'd2;
  localparam logic [2:0] StOut  = 3'd3;
  localparam logic [2:0] StFin  = 3'd4;

  localparam logic [CNT_W-1:0] CntZero    = '0;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LumaTaps   = CNT_W'(LUMA_TAPS);
  localparam logic [CNT_W-1:0] ChromaTaps = CNT_W'(CHROMA_TAPS);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] rows_q, rows_d;
  logic [CNT_W-1:0] taps_q, taps_d;
  logic             last_tap;
  logic             last_row;

  // rows_q is never 0 outside IDLE/FIN-from-empty, so rows_q-1 cannot underflow where it is used.
  assign last_tap = (tap_q == taps_q - CntOne);
  assign last_row = (row_q == rows_q - CntOne);

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    row_d   = row_q;
    rows_d  = rows_q;
    taps_d  = taps_q;

    case (state_q)
      StIdle: begin
        if (START && !ABORT) begin
          rows_d  = NUM_ROWS;
          taps_d  = FILTER_SEL ? ChromaTaps : LumaTaps;
          tap_d   = CntZero;
          row_d   = CntZero;
          state_d = (NUM_ROWS == CntZero) ? StFin : StClr;
        end
      end
      StClr: begin
        tap_d   = CntZero;
        state_d = StMac;
      end
      StMac: begin
        if (last_tap) begin
          tap_d   = CntZero;
          state_d = StOut;
        end else begin
          tap_d = tap_q + CntOne;
        end
      end
      StOut: begin
        if (OUT_READY) begin
          if (last_row) begin
            state_d = StFin;
          end else begin
            row_d   = row_q + CntOne;
            state_d = StClr;
          end
        end
      end
      StFin: begin
        tap_d   = CntZero;
        row_d   = CntZero;
        state_d = StIdle;
      end
      default: begin
        tap_d   = CntZero;
        row_d   = CntZero;
        state_d = StIdle;
      end
    endcase

    // Cancel overrides every other transition once a job is running.
    if (ABORT && (state_q != StIdle)) begin
      tap_d   = CntZero;
      row_d   = CntZero;
      state_d = StIdle;
    end
  end

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= StIdle;
      tap_q   <= CntZero;
      row_q   <= CntZero;
      rows_q  <= CntZero;
      taps_q  <= CntZero;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      taps_q  <= taps_d;
    end
  end

  assign TAP_IDX   = tap_q;
  assign ROW_IDX   = row_q;
  assign ACC_CLR   = (state_q == StClr);
  assign ACC_EN    = (state_q == StMac);
  assign OUT_VALID = (state_q == StOut);
  assign BUSY      = (state_q != StIdle);
  assign DONE      = (state_q == StFin);

endmodule
